// File: rtl/lc3_execute_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lc3_execute_pkg
// Brief   : Shared widths, opcodes and control-field encodings for LC3 execute
// Revision: 1.0
// ============================================================================
package lc3_execute_pkg;

  localparam int WORD_W = 16;
  localparam int REG_W  = 3;

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_RTI  = 4'b1000;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_RES  = 4'b1101;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_AND  = 2'b01,
    ALU_NOT  = 2'b10,
    ALU_PASS = 2'b11
  } alu_ctl_e;

  typedef enum logic [1:0] {
    PC1_OFF11 = 2'b00,
    PC1_OFF9  = 2'b01,
    PC1_OFF6  = 2'b10,
    PC1_ZERO  = 2'b11
  } pcsel1_e;

  typedef enum logic {
    PC2_REG = 1'b0,
    PC2_NPC = 1'b1
  } pcsel2_e;

  typedef enum logic {
    OP2_IMM5 = 1'b0,
    OP2_REG  = 1'b1
  } op2sel_e;

  // Bit positions inside E_Control
  localparam int EC_ALU_HI = 5;
  localparam int EC_ALU_LO = 4;
  localparam int EC_PC1_HI = 3;
  localparam int EC_PC1_LO = 2;
  localparam int EC_PC2    = 1;
  localparam int EC_OP2    = 0;

endpackage
`default_nettype wire

// File: rtl/lc3_execute_if.sv
`default_nettype none
// ============================================================================
// Module  : lc3_execute_if
// Brief   : Decode/regfile-facing bundle of the LC3 execute stage
// Revision: 1.0
// ============================================================================
interface lc3_execute_if;
  import lc3_execute_pkg::*;

  logic                enable_execute;
  logic [WORD_W-1:0]   IR;
  logic [WORD_W-1:0]   npc_in;
  logic [5:0]          E_Control;
  logic [1:0]          W_Control_in;
  logic                Mem_Control_in;
  logic [WORD_W-1:0]   VSR1;
  logic [WORD_W-1:0]   VSR2;
  logic                bypass_alu_1;
  logic                bypass_alu_2;
  logic                bypass_mem_1;
  logic                bypass_mem_2;
  logic [WORD_W-1:0]   Mem_Bypass_Val;
  logic [REG_W-1:0]    sr1;
  logic [REG_W-1:0]    sr2;
  logic [WORD_W-1:0]   aluout;
  logic [WORD_W-1:0]   pcout;
  logic [WORD_W-1:0]   M_Data;
  logic [WORD_W-1:0]   IR_Exec;
  logic [REG_W-1:0]    dr;
  logic [2:0]          NZP;
  logic [1:0]          W_Control_out;
  logic                Mem_Control_out;

  modport master (
    output enable_execute, IR, npc_in, E_Control, W_Control_in, Mem_Control_in,
           VSR1, VSR2, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
           Mem_Bypass_Val,
    input  sr1, sr2, aluout, pcout, M_Data, IR_Exec, dr, NZP, W_Control_out,
           Mem_Control_out
  );

  modport slave (
    input  enable_execute, IR, npc_in, E_Control, W_Control_in, Mem_Control_in,
           VSR1, VSR2, bypass_alu_1, bypass_alu_2, bypass_mem_1, bypass_mem_2,
           Mem_Bypass_Val,
    output sr1, sr2, aluout, pcout, M_Data, IR_Exec, dr, NZP, W_Control_out,
           Mem_Control_out
  );

endinterface
`default_nettype wire

// File: rtl/lc3_execute_alu.sv
`default_nettype none
// ============================================================================
// Module  : lc3_alu
// Brief   : Combinational LC3 ALU (add, and, not, pass-through)
// Revision: 1.0
// ============================================================================
module lc3_alu
  import lc3_execute_pkg::*;
(
  input  wire logic [WORD_W-1:0] i_a,
  input  wire logic [WORD_W-1:0] i_op2,
  input  wire alu_ctl_e          i_alu_control,
  output logic      [WORD_W-1:0] o_result
);

  always_comb begin
    o_result = '0;
    case (i_alu_control)
      ALU_ADD:  o_result = i_a + i_op2;
      ALU_AND:  o_result = i_a & i_op2;
      ALU_NOT:  o_result = ~i_a;
      ALU_PASS: o_result = i_a;
      default:  o_result = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lc3_execute.sv
`default_nettype none
// ============================================================================
// Module  : lc3_execute
// Brief   : LC3 execute stage: operand forwarding, ALU, address adder, output regs
// Revision: 1.0
// ============================================================================
module lc3_execute
  import lc3_execute_pkg::*;
(
  input  wire logic clock,
  input  wire logic reset,
  lc3_execute_if.slave ex
);

  logic [3:0]        w_opcode;
  logic              w_is_store;
  logic [WORD_W-1:0] w_opa;
  logic [WORD_W-1:0] w_opb;
  logic [WORD_W-1:0] w_op2;
  logic [WORD_W-1:0] w_alu_result;
  logic [WORD_W-1:0] w_offset;
  logic [WORD_W-1:0] w_base;
  logic [WORD_W-1:0] w_pcout_next;
  logic [WORD_W-1:0] w_aluout_next;
  logic [2:0]        w_nzp_next;
  alu_ctl_e          w_alu_ctl;
  pcsel1_e           w_pcsel1;
  pcsel2_e           w_pcsel2;
  op2sel_e           w_op2sel;

  logic [WORD_W-1:0] r_aluout;
  logic [WORD_W-1:0] r_pcout;
  logic [WORD_W-1:0] r_m_data;
  logic [WORD_W-1:0] r_ir_exec;
  logic [REG_W-1:0]  r_dr;
  logic [2:0]        r_nzp;
  logic [1:0]        r_w_control;
  logic              r_mem_control;

  assign w_opcode   = ex.IR[15:12];
  assign w_alu_ctl  = alu_ctl_e'(ex.E_Control[EC_ALU_HI:EC_ALU_LO]);
  assign w_pcsel1   = pcsel1_e'(ex.E_Control[EC_PC1_HI:EC_PC1_LO]);
  assign w_pcsel2   = pcsel2_e'(ex.E_Control[EC_PC2]);
  assign w_op2sel   = op2sel_e'(ex.E_Control[EC_OP2]);

  // Stores read the data register from the dr field rather than IR[2:0]
  assign w_is_store = (w_opcode == OP_ST) || (w_opcode == OP_STI) || (w_opcode == OP_STR);
  assign ex.sr1     = ex.IR[8:6];
  assign ex.sr2     = w_is_store ? ex.IR[11:9] : ex.IR[2:0];

  // ALU forwarding uses the pre-edge aluout so back-to-back dependents work
  assign w_opa = ex.bypass_alu_1 ? r_aluout :
                 ex.bypass_mem_1 ? ex.Mem_Bypass_Val : ex.VSR1;
  assign w_opb = ex.bypass_alu_2 ? r_aluout :
                 ex.bypass_mem_2 ? ex.Mem_Bypass_Val : ex.VSR2;

  assign w_op2 = (w_op2sel == OP2_REG) ? w_opb
                                       : {{(WORD_W-5){ex.IR[4]}}, ex.IR[4:0]};

  lc3_alu u_alu (
    .i_a           (w_opa),
    .i_op2         (w_op2),
    .i_alu_control (w_alu_ctl),
    .o_result      (w_alu_result)
  );

  always_comb begin
    w_offset = '0;
    case (w_pcsel1)
      PC1_OFF11: w_offset = {{(WORD_W-11){ex.IR[10]}}, ex.IR[10:0]};
      PC1_OFF9:  w_offset = {{(WORD_W-9){ex.IR[8]}},   ex.IR[8:0]};
      PC1_OFF6:  w_offset = {{(WORD_W-6){ex.IR[5]}},   ex.IR[5:0]};
      PC1_ZERO:  w_offset = '0;
      default:   w_offset = '0;
    endcase
  end

  assign w_base       = (w_pcsel2 == PC2_NPC) ? ex.npc_in : w_opa;
  assign w_pcout_next = w_base + w_offset;

  always_comb begin
    w_aluout_next = w_pcout_next;
    w_nzp_next    = 3'b000;
    case (w_opcode)
      OP_ADD, OP_AND, OP_NOT: w_aluout_next = w_alu_result;
      default:                w_aluout_next = w_pcout_next;
    endcase
    case (w_opcode)
      OP_BR:   w_nzp_next = ex.IR[11:9];
      OP_JMP:  w_nzp_next = 3'b111;
      default: w_nzp_next = 3'b000;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_aluout      <= '0;
      r_pcout       <= '0;
      r_m_data      <= '0;
      r_ir_exec     <= '0;
      r_dr          <= '0;
      r_nzp         <= '0;
      r_w_control   <= '0;
      r_mem_control <= 1'b0;
    end else if (ex.enable_execute) begin
      r_aluout      <= w_aluout_next;
      r_pcout       <= w_pcout_next;
      r_m_data      <= w_opb;
      r_ir_exec     <= ex.IR;
      r_dr          <= ex.IR[11:9];
      r_nzp         <= w_nzp_next;
      r_w_control   <= ex.W_Control_in;
      r_mem_control <= ex.Mem_Control_in;
    end
  end

  assign ex.aluout          = r_aluout;
  assign ex.pcout           = r_pcout;
  assign ex.M_Data          = r_m_data;
  assign ex.IR_Exec         = r_ir_exec;
  assign ex.dr              = r_dr;
  assign ex.NZP             = r_nzp;
  assign ex.W_Control_out   = r_w_control;
  assign ex.Mem_Control_out = r_mem_control;

endmodule
`default_nettype wire

// File: tb/tb_lc3_execute.sv
`default_nettype none
// ============================================================================
// Module  : tb_lc3_execute
// Brief   : Scoreboard bench for lc3_execute using hand-computed directed vectors
// Revision: 1.0
// ============================================================================
module tb_lc3_execute;

  typedef struct packed {
    logic [15:0] alu;
    logic [15:0] pc;
    logic [15:0] md;
    logic [15:0] ir;
    logic [2:0]  dr;
    logic [2:0]  nzp;
    logic [1:0]  wc;
    logic        mc;
  } exp_t;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] npc;
    logic [5:0]  ectl;
    logic [1:0]  wc;
    logic        mc;
    logic [15:0] vsr1;
    logic [15:0] vsr2;
    logic [3:0]  byp;     // {alu_1, alu_2, mem_1, mem_2}
    logic [15:0] memval;
    logic [2:0]  sr1;
    logic [2:0]  sr2;
    exp_t        exp;
  } vec_t;

  logic clock;
  logic reset;
  int   checks;
  int   failures;
  exp_t exp_q[$];
  exp_t last_exp;
  exp_t mon_e;
  vec_t vecs[12];

  lc3_execute_if bus ();

  lc3_execute dut (
    .clock (clock),
    .reset (reset),
    .ex    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " aluout"},  bus.aluout,  16'h0);
    chk({tag, " pcout"},   bus.pcout,   16'h0);
    chk({tag, " M_Data"},  bus.M_Data,  16'h0);
    chk({tag, " IR_Exec"}, bus.IR_Exec, 16'h0);
    chk({tag, " dr"},      {13'd0, bus.dr},  16'h0);
    chk({tag, " NZP"},     {13'd0, bus.NZP}, 16'h0);
    chk({tag, " W_Control_out"},   {14'd0, bus.W_Control_out},  16'h0);
    chk({tag, " Mem_Control_out"}, {15'd0, bus.Mem_Control_out}, 16'h0);
  endtask

  task automatic apply(input vec_t v, input bit en);
    @(negedge clock);
    bus.IR             = v.ir;
    bus.npc_in         = v.npc;
    bus.E_Control      = v.ectl;
    bus.W_Control_in   = v.wc;
    bus.Mem_Control_in = v.mc;
    bus.VSR1           = v.vsr1;
    bus.VSR2           = v.vsr2;
    bus.bypass_alu_1   = v.byp[3];
    bus.bypass_alu_2   = v.byp[2];
    bus.bypass_mem_1   = v.byp[1];
    bus.bypass_mem_2   = v.byp[0];
    bus.Mem_Bypass_Val = v.memval;
    bus.enable_execute = en;
    if (en) begin
      exp_q.push_back(v.exp);
      last_exp = v.exp;
    end else begin
      exp_q.push_back(last_exp);
    end
    #1;
    chk("sr1", {13'd0, bus.sr1}, {13'd0, v.sr1});
    chk("sr2", {13'd0, bus.sr2}, {13'd0, v.sr2});
  endtask

  // Monitor: one expected entry per rising edge while the queue holds work
  always begin
    @(posedge clock);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      #1;
      chk("aluout",  bus.aluout,  mon_e.alu);
      chk("pcout",   bus.pcout,   mon_e.pc);
      chk("M_Data",  bus.M_Data,  mon_e.md);
      chk("IR_Exec", bus.IR_Exec, mon_e.ir);
      chk("dr",      {13'd0, bus.dr},  {13'd0, mon_e.dr});
      chk("NZP",     {13'd0, bus.NZP}, {13'd0, mon_e.nzp});
      chk("W_Control_out",   {14'd0, bus.W_Control_out},   {14'd0, mon_e.wc});
      chk("Mem_Control_out", {15'd0, bus.Mem_Control_out}, {15'd0, mon_e.mc});
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    last_exp = '0;
    //          ir       npc      ectl       wc     mc    vsr1     vsr2     byp      memval   sr1   sr2    alu      pc       md       ir       dr    nzp      wc     mc
    vecs[0]  = '{16'h1283,16'h3000,6'b000001,2'b01,1'b0,16'h0005,16'h0007,4'b0000,16'h0000,3'd2,3'd3,'{16'h000C,16'h0288,16'h0007,16'h1283,3'd1,3'b000,2'b01,1'b0}};
    vecs[1]  = '{16'h1061,16'h3001,6'b000000,2'b01,1'b0,16'hDEAD,16'h0000,4'b1010,16'hBEEF,3'd1,3'd1,'{16'h000D,16'h006D,16'h0000,16'h1061,3'd0,3'b000,2'b01,1'b0}};
    vecs[2]  = '{16'h5AA5,16'h3002,6'b010000,2'b10,1'b1,16'h00FF,16'h1111,4'b0000,16'h0000,3'd2,3'd5,'{16'h0005,16'h03A4,16'h1111,16'h5AA5,3'd5,3'b000,2'b10,1'b1}};
    vecs[3]  = '{16'h0FFE,16'h3001,6'b000110,2'b00,1'b0,16'hAAAA,16'h5555,4'b0000,16'h0000,3'd7,3'd6,'{16'h2FFF,16'h2FFF,16'h5555,16'h0FFE,3'd7,3'b111,2'b00,1'b0}};
    vecs[4]  = '{16'h7703,16'h3004,6'b001000,2'b00,1'b1,16'h4000,16'h1234,4'b0000,16'h0000,3'd4,3'd3,'{16'h4003,16'h4003,16'h1234,16'h7703,3'd3,3'b000,2'b00,1'b1}};
    vecs[5]  = '{16'h94FF,16'h3005,6'b100000,2'b11,1'b0,16'h1234,16'h5678,4'b0011,16'h00F0,3'd3,3'd7,'{16'hFF0F,16'hFDEF,16'h00F0,16'h94FF,3'd2,3'b000,2'b11,1'b0}};
    vecs[6]  = '{16'h1946,16'h3006,6'b000001,2'b01,1'b0,16'h0001,16'h9999,4'b0101,16'h1111,3'd5,3'd6,'{16'hFF10,16'h0147,16'hFF0F,16'h1946,3'd4,3'b000,2'b01,1'b0}};
    vecs[7]  = '{16'hC1C0,16'h3007,6'b111100,2'b00,1'b0,16'h3456,16'h0BAD,4'b0000,16'h0000,3'd7,3'd0,'{16'h3456,16'h3456,16'h0BAD,16'hC1C0,3'd0,3'b111,2'b00,1'b0}};
    vecs[8]  = '{16'h1021,16'h3008,6'b000000,2'b01,1'b0,16'hFFFF,16'h7777,4'b0000,16'h0000,3'd0,3'd1,'{16'h0000,16'h0020,16'h7777,16'h1021,3'd0,3'b000,2'b01,1'b0}};
    vecs[9]  = '{16'hD23F,16'h4000,6'b000110,2'b10,1'b1,16'h0000,16'h0102,4'b0000,16'h0000,3'd0,3'd7,'{16'h403F,16'h403F,16'h0102,16'hD23F,3'd1,3'b000,2'b10,1'b1}};
    vecs[10] = '{16'h1283,16'h3009,6'b110001,2'b00,1'b0,16'h0ABC,16'h0007,4'b0000,16'h0000,3'd2,3'd3,'{16'h0ABC,16'h0D3F,16'h0007,16'h1283,3'd1,3'b000,2'b00,1'b0}};
    vecs[11] = '{16'h1061,16'h3001,6'b000000,2'b01,1'b0,16'hDEAD,16'h0000,4'b1000,16'h0000,3'd1,3'd1,'{16'h0001,16'h0061,16'h0000,16'h1061,3'd0,3'b000,2'b01,1'b0}};

    bus.enable_execute = 1'b0;
    bus.IR             = '0;
    bus.npc_in         = '0;
    bus.E_Control      = '0;
    bus.W_Control_in   = '0;
    bus.Mem_Control_in = 1'b0;
    bus.VSR1           = '0;
    bus.VSR2           = '0;
    bus.bypass_alu_1   = 1'b0;
    bus.bypass_alu_2   = 1'b0;
    bus.bypass_mem_1   = 1'b0;
    bus.bypass_mem_2   = 1'b0;
    bus.Mem_Bypass_Val = '0;
    reset = 1'b0;
    #1 reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 chk_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 11; i++) apply(vecs[i], 1'b1);
    // Hold: inputs keep changing, registered outputs must not
    for (int i = 2; i < 5; i++) apply(vecs[i], 1'b0);

    @(negedge clock);
    bus.enable_execute = 1'b0;
    @(posedge clock);
    #3 reset = 1'b1;
    #1 chk_zero("async reset");
    @(negedge clock);
    reset = 1'b0;
    apply(vecs[11], 1'b1);

    @(negedge clock);
    bus.enable_execute = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: actual=%0d pending required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
